// File: rtl/jk_counter_ctrl_pkg.sv
// Shared types for the JK counter controller: command opcodes, FSM states, helpers.
package jk_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // True for the two multi-step counting commands.
    function automatic logic is_count(input op_t op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_counter_ctrl_if.sv
// Command handshake between the host sequencer (master) and the controller (slave).
interface jk_counter_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
);
    import jk_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/jk_counter_ctrl_jkff.sv
// Single JK flip-flop cell of the register bank.
module jkff (
    input  logic CLK,
    input  logic RESET,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK behaviour: hold, reset, set, toggle; async reset clears the cell.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command-driven controller sequencing J/K inputs of a WIDTH-bit jkff register bank.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    jk_counter_ctrl_if.slave cmd,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_t           state;
    state_t           state_nxt;
    op_t              op_r;
    logic [WIDTH-1:0] data_r;
    logic [LEN_W-1:0] rem;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             accept_c;
    logic             step_c;
    logic             last_c;
    logic             wrap_step_c;
    logic             ready_d;
    logic             busy_d;
    logic             done_d;

    // Bit i toggles when every lower bit of v is set (bit 0 always toggles).
    function automatic logic [WIDTH-1:0] prefix_and(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = acc;
            acc  = acc & v[i];
        end
        return r;
    endfunction

    assign accept_c    = (state == S_IDLE) && cmd.cmd_valid;
    assign step_c      = (state == S_EXEC) && is_count(op_r) && (rem != '0);
    assign last_c      = (state == S_EXEC) && (!is_count(op_r) || (rem <= LEN_W'(1)));
    assign wrap_step_c = step_c && (((op_r == OP_UP) && (&q)) || ((op_r == OP_DOWN) && (~|q)));

    // State register and registered handshake/status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cmd.cmd_ready <= ready_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Next-state logic: IDLE -> EXEC -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_EXEC;
            S_EXEC:  if (last_c)   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the status flops line up with it.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_nxt)
            S_IDLE:  ready_d = 1'b1;
            S_EXEC:  busy_d  = 1'b1;
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ready_d = 1'b1;
        endcase
    end

    // Command capture, remaining-step counter and sticky wrap flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_r   <= OP_CLEAR;
            data_r <= '0;
            rem    <= '0;
            wrap   <= 1'b0;
        end else if (accept_c) begin
            op_r   <= cmd.cmd_op;
            data_r <= cmd.cmd_data;
            rem    <= cmd.cmd_len;
            wrap   <= 1'b0;
        end else if (step_c) begin
            rem <= rem - LEN_W'(1);
            if (wrap_step_c) begin
                wrap <= 1'b1;
            end
        end
    end

    // J/K drive: zero (hold) everywhere except the active EXEC cycle.
    always_comb begin
        j = '0;
        k = '0;
        if (state == S_EXEC) begin
            case (op_r)
                OP_CLEAR: k = '1;
                OP_LOAD: begin
                    j = data_r & ~q;
                    k = ~data_r & q;
                end
                OP_UP: begin
                    if (step_c) begin
                        j = prefix_and(q);
                        k = prefix_and(q);
                    end
                end
                OP_DOWN: begin
                    if (step_c) begin
                        j = prefix_and(~q);
                        k = prefix_and(~q);
                    end
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    // Register bank: q comes straight from the cells.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jkff u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .j     (j[gi]),
            .k     (k[gi]),
            .q     (q[gi])
        );
    end

endmodule
